// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks destination registers and result latency per
// stage, raises a load-use stall and selects operand forwarding paths.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             useRsD,
  input  logic             useRtD,
  input  logic             tUseRsD,
  input  logic [1:0]       tUseRtD,
  input  logic [4:0]       wAddrD,
  input  logic             regWriteD,
  input  logic [1:0]       tNewD,
  output logic             stall,
  output logic [1:0]       fwdRsD,
  output logic [1:0]       fwdRtD,
  output logic [1:0]       fwdRsE,
  output logic [1:0]       fwdRtE,
  output logic             fwdRtM,
  output logic [CNT_W-1:0] stallCnt
);

  logic [4:0]       addr_e_r, rs_e_r, rt_e_r;
  logic [1:0]       tnew_e_r;
  logic [4:0]       addr_m_r, rt_m_r;
  logic [1:0]       tnew_m_r;
  logic [4:0]       addr_w_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [4:0]       waddr_d_s;
  logic [1:0]       tnew_m_next_s;
  logic             stall_rs_s, stall_rt_s;

  // A source stalls when a producer in E or M will not have its result in time.
  function automatic logic src_stall(input logic use_src, input logic [4:0] src,
                                     input logic [1:0] t_use,
                                     input logic [4:0] a_e, input logic [1:0] t_e,
                                     input logic [4:0] a_m, input logic [1:0] t_m);
    src_stall = use_src && (src != 5'd0) &&
                (((src == a_e) && (t_e > t_use)) || ((src == a_m) && (t_m > t_use)));
  endfunction

  // D-stage select: E result wins over M; only results already produced qualify.
  function automatic logic [1:0] sel_d(input logic [4:0] src,
                                       input logic [4:0] a_e, input logic [1:0] t_e,
                                       input logic [4:0] a_m, input logic [1:0] t_m);
    if (src == 5'd0) begin
      sel_d = 2'd0;
    end else if ((src == a_e) && (t_e == 2'd0)) begin
      sel_d = 2'd2;
    end else if ((src == a_m) && (t_m == 2'd0)) begin
      sel_d = 2'd1;
    end else begin
      sel_d = 2'd0;
    end
  endfunction

  // E-stage select: M result (if ready) wins over W.
  function automatic logic [1:0] sel_e(input logic [4:0] src,
                                       input logic [4:0] a_m, input logic [1:0] t_m,
                                       input logic [4:0] a_w);
    if (src == 5'd0) begin
      sel_e = 2'd0;
    end else if ((src == a_m) && (t_m == 2'd0)) begin
      sel_e = 2'd2;
    end else if (src == a_w) begin
      sel_e = 2'd1;
    end else begin
      sel_e = 2'd0;
    end
  endfunction

  // Resolve the D destination and the decremented latency entering M.
  always_comb begin
    waddr_d_s     = 5'd0;
    tnew_m_next_s = 2'd0;
    if (regWriteD) begin
      waddr_d_s = wAddrD;
    end else begin
      waddr_d_s = 5'd0;
    end
    if (tnew_e_r != 2'd0) begin
      tnew_m_next_s = tnew_e_r - 2'd1;
    end else begin
      tnew_m_next_s = 2'd0;
    end
  end

  // Stall and forwarding selects from current tracking state and D inputs.
  always_comb begin
    stall_rs_s = src_stall(useRsD, rsD, {1'b0, tUseRsD}, addr_e_r, tnew_e_r, addr_m_r, tnew_m_r);
    stall_rt_s = src_stall(useRtD, rtD, tUseRtD, addr_e_r, tnew_e_r, addr_m_r, tnew_m_r);
    stall      = stall_rs_s | stall_rt_s;
    fwdRsD     = sel_d(rsD, addr_e_r, tnew_e_r, addr_m_r, tnew_m_r);
    fwdRtD     = sel_d(rtD, addr_e_r, tnew_e_r, addr_m_r, tnew_m_r);
    fwdRsE     = sel_e(rs_e_r, addr_m_r, tnew_m_r, addr_w_r);
    fwdRtE     = sel_e(rt_e_r, addr_m_r, tnew_m_r, addr_w_r);
    if ((rt_m_r != 5'd0) && (rt_m_r == addr_w_r)) begin
      fwdRtM = 1'b1;
    end else begin
      fwdRtM = 1'b0;
    end
    stallCnt = stall_cnt_r;
  end

  // Stage tracking registers; a stall injects a bubble into E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_e_r <= 5'd0;
      rs_e_r   <= 5'd0;
      rt_e_r   <= 5'd0;
      tnew_e_r <= 2'd0;
      addr_m_r <= 5'd0;
      rt_m_r   <= 5'd0;
      tnew_m_r <= 2'd0;
      addr_w_r <= 5'd0;
    end else begin
      if (stall) begin
        addr_e_r <= 5'd0;
        rs_e_r   <= 5'd0;
        rt_e_r   <= 5'd0;
        tnew_e_r <= 2'd0;
      end else begin
        addr_e_r <= waddr_d_s;
        rs_e_r   <= rsD;
        rt_e_r   <= rtD;
        tnew_e_r <= tNewD;
      end
      addr_m_r <= addr_e_r;
      rt_m_r   <= rt_e_r;
      tnew_m_r <= tnew_m_next_s;
      addr_w_r <= addr_m_r;
    end
  end

  // Stall-cycle statistics, wrapping naturally at the counter width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else if (stall) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed pipeline scenarios, a mid-stall
// asynchronous reset and random instruction streams against an age-based model.
module tb_hazard_unit;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rsD, rtD, wAddrD;
  logic          useRsD, useRtD, tUseRsD, regWriteD;
  logic [1:0]    tUseRtD, tNewD;
  logic          stall, fwdRtM;
  logic [1:0]    fwdRsD, fwdRtD, fwdRsE, fwdRtE;
  logic [CW-1:0] stallCnt;

  hazard_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
    .tUseRsD(tUseRsD), .tUseRtD(tUseRtD), .wAddrD(wAddrD), .regWriteD(regWriteD),
    .tNewD(tNewD), .stall(stall), .fwdRsD(fwdRsD), .fwdRtD(fwdRtD), .fwdRsE(fwdRsE),
    .fwdRtE(fwdRtE), .fwdRtM(fwdRtM), .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, tu_rs;
    logic [1:0] tu_rt;
    logic [4:0] wa;
    logic       rw;
    logic [1:0] tn;
  } din_t;

  typedef struct {
    logic [4:0] dst, rs, rt;
    int         tn;
  } ins_t;

  typedef struct {
    int stall, frsd, frtd, frse, frte, frtm, cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: instructions in E/M with their entry latency; W keeps only dst.
  ins_t          m_e, m_m;
  logic [4:0]    m_w;
  logic [CW-1:0] m_cnt;
  din_t          cur;
  int            prev_stall;

  function automatic din_t nop();
    din_t d;
    d = '0;
    return d;
  endfunction

  function automatic int rem(int tn, int age);
    return (tn - age > 0) ? tn - age : 0;
  endfunction

  function automatic int need(logic [4:0] r, logic u, int tuse);
    if (!u || r == 5'd0) return 0;
    if (r == m_e.dst && rem(m_e.tn, 0) > tuse) return 1;
    if (r == m_m.dst && rem(m_m.tn, 1) > tuse) return 1;
    return 0;
  endfunction

  function automatic int fsel_d(logic [4:0] r);
    if (r == 5'd0) return 0;
    if (r == m_e.dst && rem(m_e.tn, 0) == 0) return 2;
    if (r == m_m.dst && rem(m_m.tn, 1) == 0) return 1;
    return 0;
  endfunction

  function automatic int fsel_e(logic [4:0] r);
    if (r == 5'd0) return 0;
    if (r == m_m.dst && rem(m_m.tn, 1) == 0) return 2;
    if (r == m_w) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_e = '{5'd0, 5'd0, 5'd0, 0};
    m_m = '{5'd0, 5'd0, 5'd0, 0};
    m_w = 5'd0;
    m_cnt = '0;
    prev_stall = 0;
    cur = nop();
  endtask

  task automatic apply(input din_t d);
    rsD = d.rs; rtD = d.rt; useRsD = d.use_rs; useRtD = d.use_rt;
    tUseRsD = d.tu_rs; tUseRtD = d.tu_rt; wAddrD = d.wa; regWriteD = d.rw; tNewD = d.tn;
  endtask

  // One clock: advance the model across the edge, present D (held while stalled), queue expectations.
  task automatic step(input din_t d);
    exp_t x;
    @(posedge clk);
    m_w = m_m.dst;
    m_m = m_e;
    if (prev_stall != 0) begin
      m_e = '{5'd0, 5'd0, 5'd0, 0};
      m_cnt = m_cnt + 1'b1;
    end else begin
      m_e.dst = (cur.rw && cur.wa != 5'd0) ? cur.wa : 5'd0;
      m_e.rs = cur.rs;
      m_e.rt = cur.rt;
      m_e.tn = int'(cur.tn);
      cur = d;
    end
    #1;
    apply(cur);
    x.stall = (need(cur.rs, cur.use_rs, int'(cur.tu_rs)) != 0 ||
               need(cur.rt, cur.use_rt, int'(cur.tu_rt)) != 0) ? 1 : 0;
    x.frsd = fsel_d(cur.rs);
    x.frtd = fsel_d(cur.rt);
    x.frse = fsel_e(m_e.rs);
    x.frte = fsel_e(m_e.rt);
    x.frtm = (m_m.rt != 5'd0 && m_m.rt == m_w) ? 1 : 0;
    x.cnt  = int'(m_cnt);
    prev_stall = x.stall;
    sb.push_back(x);
  endtask

  // Issue one instruction, repeating the edge while the model predicts a stall.
  task automatic issue(input din_t d);
    int guard;
    step(d);
    guard = 0;
    while (prev_stall != 0 && guard < 8) begin
      step(d);
      guard++;
    end
    if (guard >= 8) chk("stall_bound", guard, 0);
  endtask

  function automatic din_t mk(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic tus, logic [1:0] tut, logic [4:0] wa, logic rw,
                              logic [1:0] tn);
    din_t d;
    d.rs = rs; d.rt = rt; d.use_rs = urs; d.use_rt = urt; d.tu_rs = tus; d.tu_rt = tut;
    d.wa = wa; d.rw = rw; d.tn = tn;
    return d;
  endfunction

  // Monitor: outputs are valid every cycle, compared mid-cycle on the falling edge.
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("stall", int'(stall), mon_e.stall);
      chk("fwdRsD", int'(fwdRsD), mon_e.frsd);
      chk("fwdRtD", int'(fwdRtD), mon_e.frtd);
      chk("fwdRsE", int'(fwdRsE), mon_e.frse);
      chk("fwdRtE", int'(fwdRtE), mon_e.frte);
      chk("fwdRtM", int'(fwdRtM), mon_e.frtm);
      chk("stallCnt", int'(stallCnt), mon_e.cnt);
    end
  end

  din_t lw8, add_r8, beq_r8, add9, sub_r9, jal_i, jr31, add0, rd0, lw5, sw5, rnd;

  initial begin
    lw8    = mk(5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 2'd0, 5'd8, 1'b1, 2'd2);
    add_r8 = mk(5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 2'd1, 5'd10, 1'b1, 2'd1);
    beq_r8 = mk(5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
    add9   = mk(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 2'd1, 5'd9, 1'b1, 2'd1);
    sub_r9 = mk(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 2'd1, 5'd11, 1'b1, 2'd1);
    jal_i  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd31, 1'b1, 2'd0);
    jr31   = mk(5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
    add0   = mk(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 2'd1, 5'd0, 1'b1, 2'd1);
    rd0    = mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd12, 1'b1, 2'd1);
    lw5    = mk(5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 2'd0, 5'd5, 1'b1, 2'd2);
    sw5    = mk(5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0);

    model_clear();
    apply(cur);
    reset = 1'b1;
    #12;
    chk("rst_stall", int'(stall), 0);
    chk("rst_fwd", int'({fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM}), 0);
    chk("rst_cnt", int'(stallCnt), 0);
    @(negedge clk);
    reset = 1'b0;

    // Load-use, branch-use, ALU chain, jal/jr, $0 writes, load-store.
    issue(lw8); issue(add_r8); issue(nop()); issue(nop());
    issue(lw8); issue(beq_r8); issue(nop()); issue(nop());
    issue(add9); issue(sub_r9); issue(nop()); issue(nop());
    issue(jal_i); issue(jr31); issue(nop());
    issue(add0); issue(rd0); issue(nop());
    issue(lw5); issue(sw5); issue(nop()); issue(nop());

    // Asynchronous reset in the middle of a branch-use stall.
    issue(lw8);
    step(beq_r8);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_stall", int'(stall), 0);
    chk("midrst_cnt", int'(stallCnt), 0);
    chk("midrst_fwd", int'({fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM}), 0);
    model_clear();
    apply(cur);
    #1 reset = 1'b0;
    issue(beq_r8); issue(nop());

    // Random instruction stream over a small register set to provoke hazards.
    for (int i = 0; i < 2500; i++) begin
      rnd.rs     = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
      rnd.rt     = 5'($urandom_range(0, 6));
      rnd.use_rs = 1'($urandom_range(0, 1));
      rnd.use_rt = 1'($urandom_range(0, 1));
      rnd.tu_rs  = 1'($urandom_range(0, 1));
      rnd.tu_rt  = 2'($urandom_range(0, 2));
      rnd.wa     = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
      rnd.rw     = 1'($urandom_range(0, 1));
      rnd.tn     = 2'($urandom_range(0, 2));
      issue(rnd);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: CNT_W, default 32, width of the stall-cycle statistics counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rsD, rtD  input  5 each  source register numbers of the instruction in D.
REQ-005 useRsD, useRtD  input  1 each  D instruction reads rs / rt.
REQ-006 tUseRsD  input  1; tUseRtD  input  2  cycles until D instruction needs rs / rt.
REQ-007 wAddrD  input  5  destination GPR of D instruction, already resolved (rd/rt/31).
REQ-008 regWriteD  input  1  D instruction writes a GPR.
REQ-009 tNewD  input  2  E-entry tNew of D instruction (lw 2, ALU 1, jal 0).
REQ-010 stall  output  1  freeze PC and F/D register, inject a bubble into E.
REQ-011 fwdRsD, fwdRtD  output  2 each  D operand select: 0 GRF, 1 from M, 2 from E.
REQ-012 fwdRsE, fwdRtE  output  2 each  E operand select: 0 pipe register, 1 from W, 2 from M.
REQ-013 fwdRtM  output  1  M store-data select: 0 pipe register, 1 from W.
REQ-014 stallCnt  output  CNT_W  count of stall cycles since reset.

Function
REQ-015 The unit SHALL hold per-stage tracking registers: E (addrE[4:0], rsE, rtE, tNewE[1:0]), M (addrM, rtM, tNewM), W (addrW).
REQ-016 addr* SHALL be 0 when the instruction in that stage writes no GPR; regWriteD=0 or wAddrD=0 loads addr 0.
REQ-017 Without stall, E SHALL load {wAddrD, rsD, rtD, tNewD} on each rising edge.
REQ-018 With stall, E SHALL load a bubble {0,0,0,0}; the D inputs are held externally.
REQ-019 M SHALL load E each cycle, with tNewM = tNewE-1 saturating at 0; W SHALL load addrM.
REQ-020 Stall on rs SHALL be asserted iff useRsD, rsD!=0, and ((rsD==addrE and tNewE>tUseRsD) or (rsD==addrM and tNewM>tUseRsD)).
REQ-021 Stall on rt SHALL follow the same rule with useRtD, rtD, and tUseRtD; stall = rs-stall OR rt-stall (combinational).
REQ-022 fwdRsD SHALL be 2 if rsD!=0, rsD==addrE, and tNewE==0; else 1 if rsD==addrM and tNewM==0; else 0. fwdRtD is analogous.
REQ-023 fwdRsE SHALL be 2 if rsE!=0, rsE==addrM, and tNewM==0; else 1 if rsE==addrW; else 0. fwdRtE is analogous.
REQ-024 fwdRtM SHALL be 1 iff rtM!=0 and rtM==addrW.
REQ-025 A forward select SHALL never be nonzero for register 0; a newer stage SHALL win over an older one.
REQ-026 stallCnt SHALL increment by 1 on each rising edge where stall=1 and SHALL wrap modulo 2^CNT_W.
REQ-027 All select and stall outputs SHALL be combinational from current state and D inputs, valid in the same cycle.

Reset
REQ-028 On reset assertion, all tracking registers and stallCnt SHALL clear to 0 immediately, independent of clk.
REQ-029 While reset=1: stall=0, all fwd*=0, stallCnt=0; a mid-stall reset drops the bubble sequence.
REQ-030 The first rising edge after deassertion SHALL behave as normal operation from an empty pipe.

Verification
REQ-031 lw $8 in D (tNewD=2), then add using rs=$8 (tUseRsD=1) -> stall=1 for exactly 1 cycle, then fwdRsE=1 (from W) on the add's E cycle; stallCnt=1.
REQ-032 lw $8, then beq rs=$8 (tUseRsD=0) -> stall=1 for 2 consecutive cycles, then fwdRsD=0 (GRF); stallCnt=2.
REQ-033 add $9, then sub rt=$9 -> stall=0 throughout, fwdRtE=2 in the sub's E cycle.
REQ-034 jal (addr 31, tNewD=0), then jr rs=$31 -> stall=0, fwdRsD=2 while jal is in E.
REQ-035 Write to $0 by ALU op, then read of $0 -> stall=0 and all fwd*=0; lw $5, then sw rt=$5 (tUseRtD=2) -> no stall, fwdRtM=1.
REQ-036 Assert reset asynchronously in the middle of the REQ-032 stall -> stall drops to 0 before the next edge, stallCnt=0.
